dphy_hs_tx_sequencer: RTL and testbench

Lane-level sequencer for a D-PHY data lane transmitter. It walks the lane from LP-11 through the HS entry sequence (LP-01, LP-00, HS-zero, sync byte), a byte-wide HS payload burst, HS-trail and the return to LP-11. Every timed interval is measured by driving the shared 6-bit countdown timer through its enable, reload and pass signals. It sits between the packet/byte source and the lane serializer/LP drivers.

---
 rtl/dphy_hs_tx_sequencer_if.sv | 33 +++
 rtl/dphy_hs_tx_sequencer.sv | 121 ++++++++++++
 tb/tb_dphy_hs_tx_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dphy_hs_tx_sequencer_if.sv
// Lane-side bundle for the D-PHY HS transmit sequencer: payload handshake,
// LP/HS line controls and the shared countdown-timer hookup.
interface dphy_hs_tx_sequencer_if;
    logic       tx_req;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       lp_dp;
    logic       lp_dn;
    logic       hs_en;
    logic [7:0] hs_data;
    logic       busy;
    logic       tx_done;
    logic       err_underrun;
    logic       timer_en;
    logic [5:0] timer_reload;
    logic       timer_pass;

    // Source/timer side: drives requests, payload and the timer pass pulse.
    modport master (
        output tx_req, tx_valid, tx_data, tx_last, timer_pass,
        input  tx_ready, lp_dp, lp_dn, hs_en, hs_data, busy, tx_done,
               err_underrun, timer_en, timer_reload
    );

    // Sequencer side.
    modport slave (
        input  tx_req, tx_valid, tx_data, tx_last, timer_pass,
        output tx_ready, lp_dp, lp_dn, hs_en, hs_data, busy, tx_done,
               err_underrun, timer_en, timer_reload
    );
endinterface

// File: rtl/dphy_hs_tx_sequencer.sv
// D-PHY data-lane HS transmit sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero ->
// sync -> payload -> HS-trail -> LP-11, with every dwell timed by an external timer.
module dphy_hs_tx_sequencer #(
    parameter logic [5:0] T_LPX     = 6'd10,
    parameter logic [5:0] T_PREP    = 6'd8,
    parameter logic [5:0] T_ZERO    = 6'd20,
    parameter logic [5:0] T_TRAIL   = 6'd10,
    parameter logic [5:0] T_EXIT    = 6'd12,
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input logic                     clk,
    input logic                     rst,
    dphy_hs_tx_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, LPX, PREP, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT
    } state_t;

    state_t     state, state_nxt;
    logic       pass_seen;
    logic       last_bit;
    logic       expire;
    logic [7:0] trail_byte;

    logic       lp_dp_q, lp_dn_q, hs_en_q, tx_ready_q, busy_q, err_q, timer_en_q;
    logic [5:0] reload_q;

    function automatic logic is_timed(input state_t s);
        return (s == LPX) || (s == PREP) || (s == HS_ZERO) ||
               (s == HS_TRAIL) || (s == HS_EXIT);
    endfunction

    function automatic logic [5:0] reload_of(input state_t s);
        case (s)
            LPX:      return T_LPX;
            PREP:     return T_PREP;
            HS_ZERO:  return T_ZERO;
            HS_TRAIL: return T_TRAIL;
            HS_EXIT:  return T_EXIT;
            default:  return '0;
        endcase
    endfunction

    // The first pass after timer_en rises only arms the count; the second is expiry.
    assign expire = timer_en_q & bus.timer_pass & pass_seen;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.tx_req) state_nxt = LPX;
            LPX:      if (expire) state_nxt = PREP;
            PREP:     if (expire) state_nxt = HS_ZERO;
            HS_ZERO:  if (expire) state_nxt = HS_SYNC;
            HS_SYNC:  state_nxt = HS_DATA;
            HS_DATA:  if (!bus.tx_valid || bus.tx_last) state_nxt = HS_TRAIL;
            HS_TRAIL: if (expire) state_nxt = HS_EXIT;
            HS_EXIT:  if (expire) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pass_seen  <= 1'b0;
            last_bit   <= 1'b0;
            lp_dp_q    <= 1'b1;
            lp_dn_q    <= 1'b1;
            hs_en_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            timer_en_q <= 1'b0;
            reload_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                pass_seen <= 1'b0;
            else if (timer_en_q && bus.timer_pass)
                pass_seen <= 1'b1;
            if (state == HS_SYNC)
                last_bit <= SYNC_BYTE[7];
            else if (state == HS_DATA && bus.tx_valid)
                last_bit <= bus.tx_data[7];
            lp_dp_q    <= (state_nxt == IDLE) || (state_nxt == HS_EXIT);
            lp_dn_q    <= (state_nxt == IDLE) || (state_nxt == HS_EXIT) || (state_nxt == LPX);
            hs_en_q    <= (state_nxt == HS_ZERO) || (state_nxt == HS_SYNC) ||
                          (state_nxt == HS_DATA) || (state_nxt == HS_TRAIL);
            tx_ready_q <= (state_nxt == HS_DATA);
            busy_q     <= (state_nxt != IDLE);
            err_q      <= (state == HS_DATA) && !bus.tx_valid;
            timer_en_q <= is_timed(state_nxt) && (state_nxt == state);
            reload_q   <= reload_of(state_nxt);
        end
    end

    assign trail_byte = last_bit ? 8'h00 : 8'hFF;

    always_comb begin
        bus.hs_data = '0;
        case (state)
            HS_SYNC:  bus.hs_data = SYNC_BYTE;
            HS_DATA:  bus.hs_data = bus.tx_valid ? bus.tx_data : trail_byte;
            HS_TRAIL: bus.hs_data = trail_byte;
            default:  bus.hs_data = '0;
        endcase
    end

    assign bus.tx_done      = (state == HS_EXIT) && expire;
    assign bus.lp_dp        = lp_dp_q;
    assign bus.lp_dn        = lp_dn_q;
    assign bus.hs_en        = hs_en_q;
    assign bus.tx_ready     = tx_ready_q;
    assign bus.busy         = busy_q;
    assign bus.err_underrun = err_q;
    assign bus.timer_en     = timer_en_q;
    assign bus.timer_reload = reload_q;

endmodule

// File: tb/tb_dphy_hs_tx_sequencer.sv
// Directed bench for dphy_hs_tx_sequencer: default-timing and all-zero-timing
// instances, each paired with a small countdown-timer model.
module tb_dphy_hs_tx_sequencer;

    localparam logic [5:0] TLPX = 6'd10, TPREP = 6'd8, TZERO = 6'd20,
                           TTRAIL = 6'd10, TEXIT = 6'd12;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        bit          under;
        logic [7:0]  trail;
        bit          err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic       tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_data = '0;
    logic       sel = 1'b0;
    int         tests = 0, fails = 0;

    logic [5:0] cnt_a = '0, cnt_b = '0;
    logic       pass_a = 1'b0, pass_b = 1'b0;

    dphy_hs_tx_sequencer_if ifa ();
    dphy_hs_tx_sequencer_if ifb ();

    dphy_hs_tx_sequencer dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    dphy_hs_tx_sequencer #(
        .T_LPX(6'd0), .T_PREP(6'd0), .T_ZERO(6'd0), .T_TRAIL(6'd0), .T_EXIT(6'd0),
        .SYNC_BYTE(8'hB8)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.tx_req = req_a;     assign ifb.tx_req = req_b;
    assign ifa.tx_valid = tx_valid; assign ifb.tx_valid = tx_valid;
    assign ifa.tx_data = tx_data;  assign ifb.tx_data = tx_data;
    assign ifa.tx_last = tx_last;  assign ifb.tx_last = tx_last;
    assign ifa.timer_pass = pass_a; assign ifb.timer_pass = pass_b;

    always #5 clk = ~clk;

    // Timer model: cleared while disabled; pulses, reloads and counts down while enabled.
    always @(posedge clk) begin
        if (!ifa.timer_en) begin cnt_a <= '0; pass_a <= 1'b0; end
        else if (cnt_a == 0) begin pass_a <= 1'b1; cnt_a <= ifa.timer_reload; end
        else begin pass_a <= 1'b0; cnt_a <= cnt_a - 6'd1; end
    end
    always @(posedge clk) begin
        if (!ifb.timer_en) begin cnt_b <= '0; pass_b <= 1'b0; end
        else if (cnt_b == 0) begin pass_b <= 1'b1; cnt_b <= ifb.timer_reload; end
        else begin pass_b <= 1'b0; cnt_b <= cnt_b - 6'd1; end
    end

    // {lp_dp, lp_dn, hs_en, hs_data, tx_ready, busy, tx_done, err_underrun, timer_en, timer_reload}
    logic [21:0] obs_a, obs_b;
    assign obs_a = {ifa.lp_dp, ifa.lp_dn, ifa.hs_en, ifa.hs_data, ifa.tx_ready, ifa.busy,
                    ifa.tx_done, ifa.err_underrun, ifa.timer_en, ifa.timer_reload};
    assign obs_b = {ifb.lp_dp, ifb.lp_dn, ifb.hs_en, ifb.hs_data, ifb.tx_ready, ifb.busy,
                    ifb.tx_done, ifb.err_underrun, ifb.timer_en, ifb.timer_reload};

    function automatic logic [21:0] ev(input logic dp, input logic dn, input logic hs,
                                       input logic [7:0] d, input logic rdy, input logic bsy,
                                       input logic done, input logic err, input logic te,
                                       input logic [5:0] rl);
        return {dp, dn, hs, d, rdy, bsy, done, err, te, rl};
    endfunction

    localparam logic [21:0] IDLE_EXP = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

    int cycle = 0;

    // Compare at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input logic [21:0] exp, input string nm);
        logic [21:0] act;
        @(negedge clk);
        act = sel ? obs_b : obs_a;
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut_%s, cycle %0d): got %h expected %h", nm,
                     sel ? "b" : "a", cycle, act, exp);
        end
        cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input string nm, input int len, input logic dp, input logic dn,
                       input logic hs, input logic [7:0] d, input logic [5:0] rl,
                       input bit done_last, input bit err_first);
        for (int c = 0; c < len; c++)
            cyc(ev(dp, dn, hs, d, 1'b0, 1'b1, done_last && (c == len - 1),
                   err_first && (c == 0), c != 0, rl), nm);
    endtask

    task automatic set_req(input logic v);
        if (sel) req_b = v; else req_a = v;
    endtask

    task automatic run_burst(input vec_t v, input bit zero, input bit hold);
        logic [5:0] rl_lpx, rl_prep, rl_zero, rl_trail, rl_exit;
        rl_lpx   = zero ? 6'd0 : TLPX;
        rl_prep  = zero ? 6'd0 : TPREP;
        rl_zero  = zero ? 6'd0 : TZERO;
        rl_trail = zero ? 6'd0 : TTRAIL;
        rl_exit  = zero ? 6'd0 : TEXIT;
        set_req(1'b1);
        cyc(IDLE_EXP, "idle_req");
        if (!hold) set_req(1'b0);
        seg("lpx",     int'(rl_lpx) + 4,  1'b0, 1'b1, 1'b0, 8'h00, rl_lpx,  0, 0);
        seg("prep",    int'(rl_prep) + 4, 1'b0, 1'b0, 1'b0, 8'h00, rl_prep, 0, 0);
        seg("hs_zero", int'(rl_zero) + 4, 1'b0, 1'b0, 1'b1, 8'h00, rl_zero, 0, 0);
        cyc(ev(1'b0, 1'b0, 1'b1, 8'hB8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0), "hs_sync");
        for (int i = 0; i < v.n; i++) begin
            tx_valid = 1'b1;
            tx_data  = v.bytes[8*i +: 8];
            tx_last  = (i == v.n - 1) && !v.under;
            cyc(ev(1'b0, 1'b0, 1'b1, v.bytes[8*i +: 8], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0),
                "hs_data");
        end
        tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
        if (v.under)
            cyc(ev(1'b0, 1'b0, 1'b1, v.trail, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0), "bubble");
        seg("hs_trail", int'(rl_trail) + 4, 1'b0, 1'b0, 1'b1, v.trail, rl_trail, 0, v.err);
        seg("hs_exit",  int'(rl_exit) + 4,  1'b1, 1'b1, 1'b0, 8'h00, rl_exit, 1, 0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1, 32'h0000005A, 1'b0, 8'hFF, 1'b0};
        tbl[1] = '{3, 32'h007F8001, 1'b0, 8'hFF, 1'b0};
        tbl[2] = '{2, 32'h00009C33, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{1, 32'h00000080, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{0, 32'h00000000, 1'b1, 8'h00, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        sel = 1'b0;
        for (int i = 0; i < 20; i++) cyc(IDLE_EXP, "reset_idle_a");
        sel = 1'b1;
        for (int i = 0; i < 3; i++) cyc(IDLE_EXP, "reset_idle_b");

        sel = 1'b0;
        for (int t = 0; t < 5; t++) begin
            run_burst(tbl[t], 1'b0, 1'b0);
            cyc(IDLE_EXP, "post_idle");
        end

        // Reset during the fifth HS-zero cycle, then a full burst from scratch.
        set_req(1'b1);
        cyc(IDLE_EXP, "idle_req");
        set_req(1'b0);
        seg("lpx",     int'(TLPX) + 4,  1'b0, 1'b1, 1'b0, 8'h00, TLPX,  0, 0);
        seg("prep",    int'(TPREP) + 4, 1'b0, 1'b0, 1'b0, 8'h00, TPREP, 0, 0);
        seg("hs_zero", 4,               1'b0, 1'b0, 1'b1, 8'h00, TZERO, 0, 0);
        rst = 1'b1;
        cyc(ev(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, TZERO), "hs_zero_rst");
        rst = 1'b0;
        cyc(IDLE_EXP, "after_rst");
        cyc(IDLE_EXP, "after_rst");
        run_burst(tbl[0], 1'b0, 1'b0);
        cyc(IDLE_EXP, "post_idle");

        // Zero-timing instance with tx_req held high: back-to-back bursts.
        sel = 1'b1;
        run_burst(tbl[0], 1'b1, 1'b1);
        run_burst(tbl[2], 1'b1, 1'b1);
        set_req(1'b0);
        cyc(IDLE_EXP, "gap_idle_b");
        cyc(IDLE_EXP, "idle_b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
